// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: command-driven sequencer that loads, advances and samples an external LFSR
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake, accepted only in IDLE
//   cmd_op, cmd_seed, cmd_steps    0 = LOAD seed, 1 = RUN cmd_steps advances
//   abort                          cancels LOAD/RUN/CAPT
//   lfsr_load, lfsr_seed, lfsr_en  control of the LFSR
//   lfsr_q                         current LFSR value
//   busy, done, result             status, completion pulse, captured value
//   err, aborted                   rejected-LOAD and abort pulses
module lfsr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_seed,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             abort,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_en,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             aborted
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] seed_n, result_n;
  logic err_n, aborted_n;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    seed_n    = lfsr_seed;
    result_n  = result;
    err_n     = 1'b0;
    aborted_n = 1'b0;
    if (state == IDLE) begin
      if (cmd_valid && !cmd_op) begin
        state_n = cmd_seed != '0 ? LOAD : IDLE;
        seed_n  = cmd_seed != '0 ? cmd_seed : lfsr_seed;
        err_n   = cmd_seed == '0;
      end else if (cmd_valid) begin
        cnt_n   = cmd_steps;
        state_n = cmd_steps == '0 ? CAPT : RUN;
      end
    end else if (abort && state != DONE) begin
      state_n   = IDLE;
      cnt_n     = '0;
      aborted_n = 1'b1;
    end else begin
      case (state)
        LOAD: state_n = DONE;
        RUN: begin
          // counter holds the remaining enable cycles including the current one
          cnt_n   = cnt - CNT_W'(1);
          state_n = cnt == CNT_W'(1) ? CAPT : RUN;
        end
        CAPT: begin
          result_n = lfsr_q;
          state_n  = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lfsr_seed <= '0;
      result    <= '0;
      err       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lfsr_seed <= seed_n;
      result    <= result_n;
      err       <= err_n;
      aborted   <= aborted_n;
    end
  end
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign lfsr_load = state == LOAD;
  assign lfsr_en   = state == RUN;
  assign done      = state == DONE;
endmodule

// File: doc/lfsr_seq_ctrl.md
LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: width of the controlled LFSR register (seed and value).
REQ-002 Parameter CNT_W, default 16: width of the step count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  controller accepts a command; command accepted on an edge where cmd_valid & cmd_ready.
REQ-007 cmd_op  input  1  0 = LOAD seed, 1 = RUN steps.
REQ-008 cmd_seed  input  WIDTH  seed for LOAD.
REQ-009 cmd_steps  input  CNT_W  number of LFSR advances for RUN.
REQ-010 abort  input  1  cancel the operation in progress.
REQ-011 lfsr_load  output  1  load strobe to the LFSR.
REQ-012 lfsr_seed  output  WIDTH  seed value to the LFSR.
REQ-013 lfsr_en  output  1  advance enable to the LFSR.
REQ-014 lfsr_q  input  WIDTH  current LFSR register value.
REQ-015 busy  output  1  high whenever the state is not IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 result  output  WIDTH  captured LFSR value, held until the next capture.
REQ-018 err  output  1  one-cycle pulse on a rejected LOAD.
REQ-019 aborted  output  1  one-cycle pulse on an abort.

Function
REQ-020 States SHALL be IDLE, LOAD, RUN, CAPT and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-021 cmd_ready SHALL be 1 only in IDLE; busy SHALL equal (state != IDLE).
REQ-022 LOAD accepted at edge k with cmd_seed != 0:
- cycle k+1: state LOAD, lfsr_load = 1 (exactly one cycle), lfsr_seed = captured seed;
- cycle k+2: state DONE, done = 1, result unchanged;
- cycle k+3: IDLE.
REQ-023 LOAD with cmd_seed == 0 SHALL be accepted and rejected: err = 1 in cycle k+1, no lfsr_load, state stays IDLE, no done.
REQ-024 RUN accepted at edge k with N = cmd_steps > 0:
- cycles k+1..k+N: state RUN, lfsr_en = 1 for exactly N consecutive cycles, tracked by an internal CNT_W down-counter;
- cycle k+N+1: state CAPT, lfsr_en = 0, result <= lfsr_q at the end of this cycle;
- cycle k+N+2: state DONE, done = 1, new result valid;
- cycle k+N+3: IDLE.
REQ-025 RUN with N == 0 SHALL skip RUN: CAPT in cycle k+1, DONE in cycle k+2, lfsr_en never asserted.
REQ-026 N = 2^CNT_W-1 SHALL give exactly that many enable cycles, with no counter wrap.
REQ-027 abort sampled high in LOAD, RUN or CAPT:
- next cycle: state IDLE, aborted = 1, lfsr_en = lfsr_load = 0;
- no done; result unchanged.
REQ-028 abort SHALL be ignored in IDLE and DONE.
REQ-029 abort and cmd_valid high together in IDLE: the command SHALL be accepted and the abort ignored.
REQ-030 cmd_valid outside IDLE SHALL be ignored; the command SHALL be neither queued nor dropped silently, since cmd_ready = 0 signals the requester to hold.
REQ-031 lfsr_load and lfsr_en SHALL never be high in the same cycle.

Reset
REQ-032 rst high at an edge SHALL force state IDLE and, from the next cycle, outputs to: cmd_ready 1, busy/done/err/aborted/lfsr_load/lfsr_en 0, lfsr_seed 0, result 0, counter 0.
REQ-033 rst asserted mid-operation SHALL cancel the operation without a done or aborted pulse.
REQ-034 rst SHALL take priority over abort and commands.

Verification
REQ-035 LOAD seed 8'hA5 -> lfsr_load one cycle at k+1 with lfsr_seed = 8'hA5; done at k+2; cmd_ready back at k+3.
REQ-036 RUN N=5 after seed 8'h01 (bench LFSR model) -> lfsr_en high exactly 5 cycles; done at k+7; result = model value after 5 steps.
REQ-037 RUN N=0 -> no lfsr_en; done at k+2; result = lfsr_q unchanged.
REQ-038 LOAD seed 0 -> err pulse at k+1; no lfsr_load, no done; busy stays 0.
REQ-039 RUN N=100, abort at the 10th enable cycle -> lfsr_en low next cycle; aborted pulse; no done; result unchanged.
REQ-040 rst for 1 cycle during RUN N=50 -> all outputs at reset values next cycle; subsequent RUN N=3 completes normally.
